// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - power-sequencing controller for the IN and MUX switchable domains
//
// Purpose: turns level off-requests for the IN and MUX domains into ordered
// sequences. Shutdown runs isolate, save, power-off. Wake runs power-on,
// restore, de-isolate. One shared sequencer serves both domains, and
// round-robin arbitration picks between them.
//
// Ports:
//   clk            sole clock
//   reset          synchronous, active-high
//   in_off_req     level: 1 = IN domain off, 0 = IN domain on
//   mux_off_req    level: 1 = MUX domain off, 0 = MUX domain on
//   IN_PWR/MUX_PWR domain switch enables (1 = powered)
//   in_iso/mux_iso isolation enables
//   in_save/...    retention save pulses
//   in_restore/... retention restore pulses
//   in_off_stat/.. 1 when the domain is fully off (acknowledge for off_req)
//   busy           1 while a sequence is in progress
//   cur_dom        domain being sequenced (0 = IN, 1 = MUX), valid while busy
module pwr_seq_ctrl #(
  parameter int ISO_SETUP   = 2,
  parameter int SAVE_CYC    = 1,
  parameter int PWR_SETTLE  = 4,
  parameter int RESTORE_CYC = 1,
  parameter int MIN_OFF     = 8,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_off_req,
  input  logic mux_off_req,
  output logic IN_PWR,
  output logic MUX_PWR,
  output logic in_iso,
  output logic mux_iso,
  output logic in_save,
  output logic mux_save,
  output logic in_restore,
  output logic mux_restore,
  output logic in_off_stat,
  output logic mux_off_stat,
  output logic busy,
  output logic cur_dom
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISO,
    S_SAVE,
    S_PWRUP,
    S_RESTORE
  } state_t;

  // Phase counters count down to zero, so each is loaded with (length - 1).
  localparam logic [CNT_W-1:0] C_ISO     = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] C_SAVE    = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETTLE  = CNT_W'(PWR_SETTLE - 1);
  localparam logic [CNT_W-1:0] C_RESTORE = CNT_W'(RESTORE_CYC - 1);
  localparam logic [CNT_W-1:0] C_MIN_OFF = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  // Bit 0 is the IN domain and bit 1 is the MUX domain throughout.
  state_t           r_state;
  logic [1:0]       r_pwr;
  logic [1:0]       r_iso;
  logic [1:0]       r_save;
  logic [1:0]       r_restore;
  logic [1:0]       r_off_stat;
  logic             r_busy;
  logic             r_cur_dom;
  logic             r_rr_last;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tmr_in;
  logic [CNT_W-1:0] r_tmr_mux;

  logic [1:0] w_req;
  logic [1:0] w_tmr_done;
  logic [1:0] w_pend;
  logic       w_gnt_dom;

  assign w_req = {mux_off_req, in_off_req};

  // The timer reaches zero at this edge when it is 1 now. Testing for <= 1
  // makes the domain stay off for exactly MIN_OFF cycles.
  assign w_tmr_done[0] = (r_tmr_in <= C_ONE);
  assign w_tmr_done[1] = (r_tmr_mux <= C_ONE);

  // Off requests are pending at once. Wake requests wait for the off-timer.
  assign w_pend[0] = (w_req[0] & ~r_off_stat[0]) |
                     (~w_req[0] & r_off_stat[0] & w_tmr_done[0]);
  assign w_pend[1] = (w_req[1] & ~r_off_stat[1]) |
                     (~w_req[1] & r_off_stat[1] & w_tmr_done[1]);

  // On a tie, grant the domain that was not served last.
  assign w_gnt_dom = (w_pend == 2'b11) ? ~r_rr_last : w_pend[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pwr      <= 2'b11;
      r_iso      <= 2'b00;
      r_save     <= 2'b00;
      r_restore  <= 2'b00;
      r_off_stat <= 2'b00;
      r_busy     <= 1'b0;
      r_cur_dom  <= 1'b0;
      r_rr_last  <= 1'b1;
      r_cnt      <= '0;
      r_tmr_in   <= '0;
      r_tmr_mux  <= '0;
    end else begin
      if (r_tmr_in != '0) r_tmr_in <= r_tmr_in - C_ONE;
      if (r_tmr_mux != '0) r_tmr_mux <= r_tmr_mux - C_ONE;

      case (r_state)
        S_IDLE: begin
          if (w_pend != 2'b00) begin
            r_cur_dom <= w_gnt_dom;
            r_rr_last <= w_gnt_dom;
            r_busy    <= 1'b1;
            if (!r_off_stat[w_gnt_dom]) begin
              r_iso[w_gnt_dom] <= 1'b1;
              r_cnt            <= C_ISO;
              r_state          <= S_ISO;
            end else begin
              r_pwr[w_gnt_dom] <= 1'b1;
              r_cnt            <= C_SETTLE;
              r_state          <= S_PWRUP;
            end
          end
        end

        S_ISO: begin
          if (r_cnt == '0) begin
            r_save[r_cur_dom] <= 1'b1;
            r_cnt             <= C_SAVE;
            r_state           <= S_SAVE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        S_SAVE: begin
          if (r_cnt == '0) begin
            r_save[r_cur_dom]     <= 1'b0;
            r_pwr[r_cur_dom]      <= 1'b0;
            r_off_stat[r_cur_dom] <= 1'b1;
            if (r_cur_dom) r_tmr_mux <= C_MIN_OFF;
            else           r_tmr_in  <= C_MIN_OFF;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        S_PWRUP: begin
          if (r_cnt == '0) begin
            r_restore[r_cur_dom] <= 1'b1;
            r_cnt                <= C_RESTORE;
            r_state              <= S_RESTORE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        S_RESTORE: begin
          if (r_cnt == '0) begin
            r_restore[r_cur_dom]  <= 1'b0;
            r_iso[r_cur_dom]      <= 1'b0;
            r_off_stat[r_cur_dom] <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign IN_PWR       = r_pwr[0];
  assign MUX_PWR      = r_pwr[1];
  assign in_iso       = r_iso[0];
  assign mux_iso      = r_iso[1];
  assign in_save      = r_save[0];
  assign mux_save     = r_save[1];
  assign in_restore   = r_restore[0];
  assign mux_restore  = r_restore[1];
  assign in_off_stat  = r_off_stat[0];
  assign mux_off_stat = r_off_stat[1];
  assign busy         = r_busy;
  assign cur_dom      = r_cur_dom;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - self-checking bench for pwr_seq_ctrl
module tb_pwr_seq_ctrl;

  localparam int ISO_SETUP   = 2;
  localparam int SAVE_CYC    = 1;
  localparam int PWR_SETTLE  = 4;
  localparam int RESTORE_CYC = 1;
  localparam int MIN_OFF     = 8;
  localparam int CNT_W       = 8;

  logic clk;
  logic reset;
  logic in_off_req;
  logic mux_off_req;
  logic IN_PWR, MUX_PWR, in_iso, mux_iso, in_save, mux_save;
  logic in_restore, mux_restore, in_off_stat, mux_off_stat, busy, cur_dom;

  pwr_seq_ctrl #(
    .ISO_SETUP(ISO_SETUP), .SAVE_CYC(SAVE_CYC), .PWR_SETTLE(PWR_SETTLE),
    .RESTORE_CYC(RESTORE_CYC), .MIN_OFF(MIN_OFF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_off_req(in_off_req), .mux_off_req(mux_off_req),
    .IN_PWR(IN_PWR), .MUX_PWR(MUX_PWR), .in_iso(in_iso), .mux_iso(mux_iso),
    .in_save(in_save), .mux_save(mux_save), .in_restore(in_restore),
    .mux_restore(mux_restore), .in_off_stat(in_off_stat), .mux_off_stat(mux_off_stat),
    .busy(busy), .cur_dom(cur_dom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: timestamps of the active sequence and of each shutdown.
  int         n = 0;
  bit         m_busy, m_dom, m_kind, m_rr;
  int         m_start;
  int         m_wake_ok [2];
  logic [1:0] m_pwr, m_iso, m_save, m_rest, m_off;

  task automatic model_reset();
    m_busy = 0; m_dom = 0; m_kind = 0; m_rr = 1; m_start = 0;
    m_wake_ok[0] = 0; m_wake_ok[1] = 0;
    m_pwr = 2'b11; m_iso = 2'b00; m_save = 2'b00; m_rest = 2'b00; m_off = 2'b00;
  endtask

  task automatic model_step(input bit r, input bit [1:0] req);
    int k;
    bit [1:0] p;
    bit d;
    n++;
    if (r) begin
      model_reset();
    end else if (m_busy) begin
      k = n - m_start;
      if (!m_kind) begin
        if (k == ISO_SETUP) m_save[m_dom] = 1'b1;
        if (k == ISO_SETUP + SAVE_CYC) begin
          m_save[m_dom] = 1'b0; m_pwr[m_dom] = 1'b0; m_off[m_dom] = 1'b1;
          m_wake_ok[m_dom] = n + MIN_OFF;
          m_busy = 0;
        end
      end else begin
        if (k == PWR_SETTLE) m_rest[m_dom] = 1'b1;
        if (k == PWR_SETTLE + RESTORE_CYC) begin
          m_rest[m_dom] = 1'b0; m_iso[m_dom] = 1'b0; m_off[m_dom] = 1'b0;
          m_busy = 0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++)
        p[i] = req[i] ? !m_off[i] : (m_off[i] && (n >= m_wake_ok[i]));
      if (p != 2'b00) begin
        d = (p == 2'b11) ? !m_rr : p[1];
        m_rr = d; m_dom = d; m_busy = 1; m_start = n;
        m_kind = m_off[d];
        if (!m_kind) m_iso[d] = 1'b1;
        else         m_pwr[d] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic check_model();
    logic [11:0] got, exp;
    got = {IN_PWR, MUX_PWR, in_iso, mux_iso, in_save, mux_save, in_restore,
           mux_restore, in_off_stat, mux_off_stat, busy, cur_dom & busy};
    exp = {m_pwr[0], m_pwr[1], m_iso[0], m_iso[1], m_save[0], m_save[1], m_rest[0],
           m_rest[1], m_off[0], m_off[1], m_busy, m_dom & m_busy};
    chk("model", {4'h0, got}, {4'h0, exp});
    chk("inv_save_restore", {14'h0, (in_save & in_restore), (mux_save & mux_restore)}, 16'h0);
    chk("inv_pwr_iso", {14'h0, (~IN_PWR & ~in_iso), (~MUX_PWR & ~mux_iso)}, 16'h0);
    chk("inv_pulse_iso", {14'h0, ((in_save | in_restore) & ~in_iso),
                          ((mux_save | mux_restore) & ~mux_iso)}, 16'h0);
  endtask

  task automatic step(input bit r, input bit in_v, input bit mux_v);
    reset = r; in_off_req = in_v; mux_off_req = mux_v;
    @(posedge clk);
    model_step(r, {mux_v, in_v});
    #1;
    check_model();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
  endtask

  int hold_in, hold_mux;
  bit rin, rmux;

  initial begin
    reset = 1; in_off_req = 0; mux_off_req = 0;
    model_reset();
    #1;

    // Reset state
    do_reset();
    chk("reset_outs", {4'h0, IN_PWR, MUX_PWR, in_iso, mux_iso, in_save, mux_save,
        in_restore, mux_restore, in_off_stat, mux_off_stat, busy, cur_dom}, 16'h0C00);

    // IN shutdown then wake, relative edges 0..16
    step(0, 1, 0);
    chk("e0_in_iso", {15'h0, in_iso}, 16'h1);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("e2_in_save", {15'h0, in_save}, 16'h1);
    step(0, 1, 0);
    chk("e3_in_off", {14'h0, IN_PWR, in_off_stat}, 16'h1);
    chk("e3_in_save_low", {15'h0, in_save}, 16'h0);
    chk("e3_mux_hold", {12'h0, MUX_PWR, mux_iso, mux_save, mux_restore}, 16'h8);
    step(0, 1, 0);
    for (int e = 5; e <= 10; e++) step(0, 0, 0);
    chk("e10_no_grant", {14'h0, IN_PWR, busy}, 16'h0);
    step(0, 0, 0);
    chk("e11_in_pwr", {14'h0, IN_PWR, busy}, 16'h3);
    for (int e = 12; e <= 15; e++) step(0, 0, 0);
    chk("e15_restore", {15'h0, in_restore}, 16'h1);
    step(0, 0, 0);
    chk("e16_done", {13'h0, in_restore, in_iso, in_off_stat}, 16'h0);

    // Both request off together: IN first, MUX on the edge after IN idles
    do_reset();
    step(0, 1, 1);
    chk("both_first_in", {14'h0, busy, cur_dom}, 16'h2);
    for (int e = 1; e <= 3; e++) step(0, 1, 1);
    step(0, 1, 1);
    chk("both_then_mux", {13'h0, busy, cur_dom, mux_iso}, 16'h7);
    for (int e = 5; e <= 14; e++) step(0, 1, 1);
    step(0, 0, 0);
    chk("both_wake_in_first", {13'h0, busy, cur_dom, IN_PWR}, 16'h5);
    for (int e = 16; e <= 40; e++) step(0, 0, 0);
    chk("both_awake", {12'h0, IN_PWR, MUX_PWR, in_off_stat, mux_off_stat}, 16'hC);

    // Short MUX pulse inside an IN sequence is ignored
    do_reset();
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("pulse_ignored", {14'h0, busy, mux_iso}, 16'h0);

    // MUX request held past the IN sequence starts at the first IDLE edge
    do_reset();
    step(0, 1, 0);
    for (int e = 1; e <= 3; e++) step(0, 1, 1);
    step(0, 1, 1);
    chk("held_mux_grant", {13'h0, busy, cur_dom, mux_iso}, 16'h7);
    for (int e = 5; e <= 8; e++) step(0, 1, 1);

    // Reset during SAVE of IN, then the shutdown restarts
    do_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("rst_mid_seq", {12'h0, IN_PWR, in_iso, in_save, busy}, 16'h8);
    step(0, 1, 0);
    chk("rst_restart", {14'h0, in_iso, busy}, 16'h3);
    for (int e = 0; e < 5; e++) step(0, 1, 0);
    chk("rst_restart_off", {15'h0, in_off_stat}, 16'h1);

    // Randomized requests with occasional reset, checked against the model
    do_reset();
    hold_in = 0; hold_mux = 0; rin = 0; rmux = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_in == 0) begin rin = $urandom_range(1, 0); hold_in = $urandom_range(25, 1); end
      if (hold_mux == 0) begin rmux = $urandom_range(1, 0); hold_mux = $urandom_range(25, 1); end
      hold_in--; hold_mux--;
      step(($urandom_range(299, 0) == 0), rin, rmux);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
- Power-sequencing controller for the two switchable domains of the ALU design: the input-register domain (IN_PWR) and the mux domain (MUX_PWR).
- Converts level off-requests into ordered isolate, save, power-off and power-on, restore, de-isolate sequences.
- One shared sequencer serves both domains. Arbitration between them is round-robin.
- Drives the rtl_top power-control pins directly, replacing direct toggling of IN_PWR and MUX_PWR by the bench.

Parameters:
- ISO_SETUP, 2, cycles isolation is held before save begins (>=1).
- SAVE_CYC, 1, width of the save pulse in cycles (>=1).
- PWR_SETTLE, 4, cycles from power-on to restore (>=1).
- RESTORE_CYC, 1, width of the restore pulse in cycles (>=1).
- MIN_OFF, 8, minimum power-off duration of a domain in cycles (>=1).
- CNT_W, 8, width of the internal counters; must hold the largest parameter value.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- in_off_req, input, 1, level: 1 requests the IN domain off, 0 requests it on.
- mux_off_req, input, 1, same as in_off_req for the MUX domain.
- IN_PWR, output, 1, IN domain switch enable (1 = powered).
- MUX_PWR, output, 1, MUX domain switch enable.
- in_iso, output, 1, IN domain isolation enable.
- mux_iso, output, 1, MUX domain isolation enable.
- in_save, output, 1, IN domain retention save pulse.
- mux_save, output, 1, MUX domain retention save pulse.
- in_restore, output, 1, IN domain retention restore pulse.
- mux_restore, output, 1, MUX domain retention restore pulse.
- in_off_stat, output, 1, 1 when the IN domain is fully off; acts as the acknowledge for in_off_req.
- mux_off_stat, output, 1, same as in_off_stat for the MUX domain.
- busy, output, 1, 1 while a sequence is in progress (state != IDLE).
- cur_dom, output, 1, domain being sequenced: 0 = IN, 1 = MUX. Valid only while busy.

Behaviour:
- All outputs are registered.
- Reset values:
  - IN_PWR = 1, MUX_PWR = 1.
  - All iso, save and restore outputs = 0.
  - Both off_stat = 0, busy = 0, cur_dom = 0.
  - State = IDLE, all counters = 0, rr_last = 1, so IN wins the first tie.
- A domain is pending when off_req != off_stat. A wake request (off_req = 0 while off_stat = 1) is pending only once that domain's off-timer is 0.
- IDLE:
  - Evaluates the pending flags on every edge.
  - If one domain is pending, it is granted.
  - If both are pending, the domain != rr_last is granted.
  - On grant, rr_last and cur_dom are set to the granted domain. The grant edge is the edge at which IDLE sees the pending flag.
- Shutdown sequence, states ISO → SAVE → IDLE:
  - Grant edge: iso = 1; state ISO for ISO_SETUP cycles.
  - Next: save = 1 for SAVE_CYC cycles (iso stays 1).
  - Final edge: save = 0, PWR = 0, off_stat = 1, off-timer loaded with MIN_OFF; state returns to IDLE.
- Wake sequence, states PWRUP → RESTORE → IDLE:
  - Grant edge: PWR = 1; state PWRUP for PWR_SETTLE cycles.
  - Next: restore = 1 for RESTORE_CYC cycles (iso stays 1).
  - Final edge: restore = 0, iso = 0, off_stat = 0; state returns to IDLE.
- Off-timer (one per domain): decrements by 1 each cycle while nonzero and saturates at 0.
- Sequences are atomic:
  - off_req changes during a sequence are ignored until IDLE.
  - Pending is then re-evaluated, so a request that toggled and returned within the sequence produces no action.
  - A shutdown immediately followed by a wake request still obeys MIN_OFF.
- Only the domain named by cur_dom has its iso, save, restore and PWR altered. The other domain's outputs hold.
- Invariants:
  - save and restore are never 1 at the same time.
  - PWR = 0 implies iso = 1.
  - save and restore are asserted only while iso = 1.
- Reset asserted mid-sequence forces all reset values at that edge. Powers return on without a restore, which is intentional. Pending requests are re-evaluated from IDLE afterwards.

Test Plan:
- Reset with both off_req = 0 for 3 cycles → both PWR = 1, all other outputs 0, busy = 0.
- in_off_req rises, sampled at edge 0 (defaults):
  - in_iso = 1 after edge 0.
  - in_save = 1 after edges 2–3 (high after edge 2, low after edge 3).
  - IN_PWR = 0 and in_off_stat = 1 after edge 3.
  - MUX outputs unchanged throughout.
- in_off_req falls at edge 5 after the shutdown above:
  - No grant until the off-timer is 0; grant at edge 11.
  - IN_PWR = 1 after edge 11.
  - in_restore high after edge 15, low after edge 16.
  - in_iso = 0 and in_off_stat = 0 after edge 16.
- Both off_req rise at the same edge from reset:
  - IN is sequenced first (cur_dom = 0).
  - MUX is granted on the edge after IN returns to IDLE (cur_dom = 1).
  - With both then waking after MIN_OFF, IN again goes first, since rr_last = MUX.
- mux_off_req pulses high for 2 cycles during an IN sequence → no MUX action. mux_off_req held high past the end of the IN sequence → MUX shutdown starts at the first IDLE edge.
- reset asserted during SAVE of IN → next edge IN_PWR = 1, in_iso = 0, in_save = 0, busy = 0. With in_off_req still 1 after reset, a full shutdown sequence restarts.
